// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by instruction fetch and EX-stage data access
module mem_port_arbiter #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic [7:0] if_addr,
  input  logic       ex_req,
  input  logic       ex_we,
  input  logic [7:0] ex_addr,
  input  logic [7:0] ex_wdata,
  input  logic       halted,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       if_valid,
  output logic [7:0] if_rdata,
  output logic       ex_done,
  output logic [7:0] ex_rdata,
  output logic       freeze,
  output logic       timeout_err,
  output logic       halt_ack
);

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_EX, DONE, HALT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [1:0] ex_streak;
  logic [7:0] wait_cnt;
  logic       ex_grant;
  logic       finish;
  logic [7:0] cap_data;

  // EX wins unless it has already taken three grants in a row while IF waited
  assign ex_grant = ex_req && (!if_req || ex_streak != 2'd3);
  assign finish   = mem_ack || (wait_cnt == WAIT_LAST);
  assign cap_data = mem_ack ? mem_rdata : 8'hFF;
  assign freeze   = (ex_req && !ex_done) || (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ex_streak   <= 2'd0;
      wait_cnt    <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 8'h00;
      mem_wdata   <= 8'h00;
      if_valid    <= 1'b0;
      if_rdata    <= 8'h00;
      ex_done     <= 1'b0;
      ex_rdata    <= 8'h00;
      timeout_err <= 1'b0;
      halt_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halted) begin
            state    <= HALT;
            halt_ack <= 1'b1;
          end else if (ex_grant) begin
            state     <= BUSY_EX;
            mem_req   <= 1'b1;
            mem_we    <= ex_we;
            mem_addr  <= ex_addr;
            mem_wdata <= ex_wdata;
            wait_cnt  <= 8'd0;
            if (if_req && ex_streak != 2'd3) ex_streak <= ex_streak + 2'd1;
          end else if (if_req) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 8'h00;
            wait_cnt  <= 8'd0;
            ex_streak <= 2'd0;
          end
        end
        BUSY_IF, BUSY_EX: begin
          if (finish) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_ack) timeout_err <= 1'b1;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
              if_rdata <= cap_data;
            end else begin
              ex_done  <= 1'b1;
              ex_rdata <= mem_we ? 8'h00 : cap_data;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          if_valid <= 1'b0;
          if_rdata <= 8'h00;
          ex_done  <= 1'b0;
          ex_rdata <= 8'h00;
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_req;
  logic [7:0] if_addr;
  logic       ex_req;
  logic       ex_we;
  logic [7:0] ex_addr;
  logic [7:0] ex_wdata;
  logic       halted;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       if_valid;
  logic [7:0] if_rdata;
  logic       ex_done;
  logic [7:0] ex_rdata;
  logic       freeze;
  logic       timeout_err;
  logic       halt_ack;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .halted(halted),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ex_done(ex_done), .ex_rdata(ex_rdata),
    .freeze(freeze), .timeout_err(timeout_err), .halt_ack(halt_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_ex;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ack_dly;
    logic [7:0] rdata;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; ex_req = 0; ex_we = 0; ex_addr = 0; ex_wdata = 0;
    halted = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // one complete access starting from IDLE; ack asserted in BUSY cycle ack_dly
  task automatic run_vec(input vec_t v, input logic exp_to);
    int hi;
    if (v.is_ex) begin
      ex_req = 1; ex_we = v.we; ex_addr = v.addr; ex_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    tick();
    chk("grant_mem_req", mem_req, 1);
    chk("grant_mem_addr", mem_addr, v.addr);
    chk("grant_mem_we", mem_we, v.is_ex ? v.we : 1'b0);
    chk("grant_mem_wdata", mem_wdata, v.is_ex ? v.wdata : 8'h00);
    chk("busy_freeze", freeze, v.is_ex);
    hi = 1;
    for (int k = 2; k <= v.ack_dly; k++) begin
      tick();
      if (mem_req) hi++;
    end
    mem_ack = 1; mem_rdata = v.rdata;
    tick();
    mem_ack = 0;
    chk("mem_req_cycles", hi, v.ack_dly);
    chk("done_mem_req", mem_req, 0);
    chk("done_if_valid", if_valid, !v.is_ex);
    chk("done_ex_done", ex_done, v.is_ex);
    if (v.is_ex) chk("done_ex_rdata", ex_rdata, v.exp_data);
    else         chk("done_if_rdata", if_rdata, v.exp_data);
    chk("done_timeout_err", timeout_err, exp_to);
    if_req = 0; ex_req = 0;
    tick();
    chk("idle_no_pulse", {if_valid, ex_done}, 2'b00);
  endtask

  initial begin
    logic order [5];
    int   ng;
    logic prev;
    int   hi;
    int   bad;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 2,  8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 8'h33, 8'h00, 1,  8'h5A, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 8'h3C, 3,  8'h77, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1,  8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 8'hFF, 15, 8'h12, 8'h00};

    clear_inputs();
    rst_n = 0;
    tick();
    chk("rst_outputs", {mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata},
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00});
    chk("rst_ex_outputs", {ex_done, ex_rdata, freeze, timeout_err, halt_ack}, 12'h000);

    // first grant on the first edge after release
    if_req = 1; if_addr = 8'h5E;
    tick();
    rst_n = 1;
    tick();
    chk("first_grant_req", mem_req, 1);
    chk("first_grant_addr", mem_addr, 8'h5E);
    mem_ack = 1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 0; if_req = 0;
    chk("first_grant_valid", {if_valid, if_rdata}, {1'b1, 8'hC3});
    tick();

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // simultaneous requests: EX write first, then IF
    if_req = 1; if_addr = 8'h44;
    ex_req = 1; ex_we = 1; ex_addr = 8'h20; ex_wdata = 8'h3C;
    tick();
    chk("sim_ex_first", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h20, 8'h3C});
    chk("sim_freeze_busy", freeze, 1);
    mem_ack = 1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 0;
    chk("sim_ex_done", {ex_done, ex_rdata, if_valid}, {1'b1, 8'h00, 1'b0});
    chk("sim_freeze_released", freeze, 0);
    ex_req = 0;
    tick();
    tick();
    chk("sim_if_next", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h44});
    mem_ack = 1; mem_rdata = 8'h9B;
    tick();
    mem_ack = 0; if_req = 0;
    chk("sim_if_valid", {if_valid, if_rdata}, {1'b1, 8'h9B});
    tick();

    // continuous requests with immediate ack: EX x3, IF, EX
    ex_req = 1; ex_we = 1; ex_addr = 8'h50; ex_wdata = 8'h11;
    if_req = 1; if_addr = 8'h60;
    mem_ack = 1; mem_rdata = 8'h99;
    ng = 0; prev = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (mem_req && !prev) begin
        order[ng] = mem_we;
        ng++;
      end
      prev = mem_req;
    end
    ex_req = 0; if_req = 0;
    tick(); tick(); tick();
    mem_ack = 0;
    chk("streak_grants", ng, 5);
    chk("streak_order", {order[0], order[1], order[2], order[3], order[4]}, 5'b11101);

    // timeout: no ack for WAIT_MAX cycles
    ex_req = 1; ex_we = 0; ex_addr = 8'h7A;
    tick();
    hi = 0;
    for (int c = 0; c < 40 && mem_req; c++) begin
      hi++;
      tick();
    end
    chk("timeout_req_cycles", hi, 15);
    chk("timeout_done", {ex_done, ex_rdata, timeout_err}, {1'b1, 8'hFF, 1'b1});
    ex_req = 0;
    tick();
    run_vec(vecs[1], 1'b1);
    chk("timeout_sticky", timeout_err, 1);

    // halt requested during BUSY_EX: access completes, then park
    ex_req = 1; ex_we = 0; ex_addr = 8'h70;
    tick();
    chk("halt_busy", mem_req, 1);
    halted = 1; mem_ack = 1; mem_rdata = 8'h42;
    tick();
    mem_ack = 0;
    chk("halt_ex_done", {ex_done, ex_rdata, halt_ack}, {1'b1, 8'h42, 1'b0});
    ex_req = 0;
    tick();
    tick();
    chk("halt_parked", {halt_ack, freeze, mem_req}, 3'b110);
    if_req = 1; ex_req = 1; mem_ack = 1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req || if_valid || ex_done || !halt_ack) bad++;
    end
    chk("halt_ignores_requests", bad, 0);

    do_reset();
    chk("reset_clears_sticky", {timeout_err, halt_ack}, 2'b00);

    // reset mid-access abandons the transfer
    if_req = 1; if_addr = 8'h81;
    tick();
    chk("midrst_busy", mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_req_drop", mem_req, 0);
    if_req = 0; mem_ack = 1; mem_rdata = 8'h66;
    tick();
    rst_n = 1;
    mem_ack = 0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_valid || mem_req) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    run_vec(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles BUSY_IF/BUSY_EX waits for mem_ack before timeout; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch read request; held stable with if_addr until if_valid.
REQ-005 if_addr  in  8  fetch address.
REQ-006 ex_req  in  1  EX-stage data access request; held stable with ex_we/ex_addr/ex_wdata until ex_done.
REQ-007 ex_we  in  1  1=write, 0=read.
REQ-008 ex_addr  in  8  data address.
REQ-009 ex_wdata  in  8  write data.
REQ-010 halted  in  1  core halt indication.
REQ-011 mem_req  out  1  memory port request.
REQ-012 mem_we  out  1  memory port write enable.
REQ-013 mem_addr  out  8  memory port address.
REQ-014 mem_wdata  out  8  memory port write data.
REQ-015 mem_rdata  in  8  memory read data; valid with mem_ack.
REQ-016 mem_ack  in  1  memory completion strobe.
REQ-017 if_valid  out  1  one-cycle fetch completion pulse.
REQ-018 if_rdata  out  8  fetch data; valid while if_valid=1.
REQ-019 ex_done  out  1  one-cycle data access completion pulse.
REQ-020 ex_rdata  out  8  read data; valid while ex_done=1 and ex_we was 0.
REQ-021 freeze  out  1  pipeline stall to upstream stages.
REQ-022 timeout_err  out  1  sticky timeout flag.
REQ-023 halt_ack  out  1  arbiter parked in HALT.

Function
REQ-024 FSM states SHALL be IDLE, BUSY_IF, BUSY_EX, DONE, HALT.
REQ-025 IDLE: halted=1 -> HALT, no grant; halted is sampled only in IDLE.
REQ-026 IDLE, halted=0: EX granted when ex_req=1 and (if_req=0 or ex_streak<3) -> BUSY_EX; else if_req=1 -> BUSY_IF; else stay.
REQ-027 ex_streak SHALL be a 2-bit saturating counter: +1 on each EX grant while if_req=1, cleared on each IF grant.
REQ-028 On grant, mem_addr/mem_we/mem_wdata SHALL be registered from the winning requester (IF: we=0, wdata=0) and mem_req set to 1 in the first BUSY cycle.
REQ-029 BUSY_*: mem_req, mem_we, mem_addr, mem_wdata SHALL stay constant until mem_ack=1 or timeout.
REQ-030 BUSY_* with mem_ack=1: capture mem_rdata, drop mem_req next cycle, -> DONE.
REQ-031 Timeout: wait counter reset on grant; when WAIT_MAX cycles elapse in BUSY_* without mem_ack, set timeout_err, capture data 8'hFF, -> DONE.
REQ-032 DONE (exactly one cycle): pulse if_valid/if_rdata or ex_done/ex_rdata for the served requester only; no grant; -> IDLE.
REQ-033 Minimum access time: 3 cycles grant-to-next-grant (IDLE, BUSY with immediate ack, DONE).
REQ-034 freeze SHALL be combinational: ex_req=1 and ex_done=0, or state=HALT.
REQ-035 HALT: mem_req=0, no pulses, halt_ack=1; exit only via rst_n.
REQ-036 mem_ack outside BUSY_* SHALL be ignored.
REQ-037 ex_rdata after a write SHALL be 0.

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE, ex_streak 0, wait counter 0, all outputs 0 (mem_addr, mem_wdata, if_rdata, ex_rdata = 8'h00; timeout_err 0; freeze follows REQ-034).
REQ-039 Reset mid-access SHALL abandon the transfer: mem_req drops asynchronously, no completion pulse after release.
REQ-040 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-041 IF read, ex_req=0, if_addr=8'h10, ack 2 cycles after mem_req, rdata 8'hA5 -> if_valid one cycle, if_rdata=8'hA5, mem_req 2 cycles.
REQ-042 Simultaneous if_req and ex_req (write 8'h3C to 8'h20) with ex_streak=0 -> EX served first, mem_we=1, ex_done pulse; IF served next; freeze 1 until ex_done.
REQ-043 ex_req and if_req held continuously, ack immediate -> three EX grants, then one IF grant, streak cleared.
REQ-044 No mem_ack, WAIT_MAX=15 -> mem_req high exactly 15 cycles, ex_done with ex_rdata=8'hFF, timeout_err stays 1 until reset.
REQ-045 halted=1 during BUSY_EX -> access completes, ex_done pulses, then HALT: halt_ack=1, freeze=1, later requests ignored.
REQ-046 rst_n low in BUSY_IF -> mem_req 0 immediately; after release, no if_valid until a new grant completes.
